traffic_phase_ctrl: RTL and testbench

Parametrised multi-approach traffic signal controller: successor to the fixed two-approach NS/WE controller. Sequences NUM_PHASES approaches through green, yellow and all-red intervals with tick-programmable durations. Green is demand-driven: approaches without a request are skipped, and the current green is held while no other approach requests. Sits between the tick prescaler and the lamp drivers; optional night flash mode.

---
 rtl/traffic_pkg.sv | 27 ++
 rtl/traffic_phase_ctrl_rr_phase_select.sv | 38 +++
 rtl/traffic_phase_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_traffic_phase_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types and constants for the multi-approach traffic phase controller.
// Lamp encodings are {red, yellow, green} per approach.
package traffic_pkg;

    typedef enum logic [1:0] {
        ST_GREEN  = 2'd0,
        ST_YELLOW = 2'd1,
        ST_ALLRED = 2'd2,
        ST_FLASH  = 2'd3
    } phase_state_t;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;
    localparam logic [2:0] LAMP_DARK   = 3'b000;

    // The counter only ever holds (longest interval - 1), so $clog2 of the longest interval suffices.
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/traffic_phase_ctrl_rr_phase_select.sv
// Combinational round-robin finder: first requesting approach after the active one,
// falling back to active+1 when nobody else is requesting.
module rr_phase_select #(
    parameter int NUM_PHASES = 2,
    parameter int PW         = 1
) (
    input  logic [NUM_PHASES-1:0] i_req,
    input  logic [PW-1:0]         i_active,
    output logic [PW-1:0]         o_next,
    output logic                  o_any_other
);

    logic [NUM_PHASES-1:0] w_other;
    logic [PW-1:0]         w_idx;
    int                    w_sum;

    generate
        for (genvar gi = 0; gi < NUM_PHASES; gi++) begin : g_mask
            assign w_other[gi] = i_req[gi] && (i_active != PW'(gi));
        end
    endgenerate

    assign o_any_other = |w_other;

    // Scan from the farthest candidate down so the nearest requester wins.
    always_comb begin
        w_sum  = 0;
        w_idx  = '0;
        o_next = (int'(i_active) == NUM_PHASES - 1) ? '0 : PW'(int'(i_active) + 1);
        for (int k = NUM_PHASES - 1; k >= 1; k--) begin
            w_sum = int'(i_active) + k;
            if (w_sum >= NUM_PHASES) w_sum = w_sum - NUM_PHASES;
            w_idx = PW'(w_sum);
            if (w_other[w_idx]) o_next = w_idx;
        end
    end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Demand-driven multi-approach signal sequencer (green -> yellow -> all-red -> next green).
// Optional night flash mode is compiled in when TRAFFIC_FLASH_EN is defined.
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int NUM_PHASES   = 2,
    parameter int GREEN_TICKS  = 15,
    parameter int YELLOW_TICKS = 3,
    parameter int ALLRED_TICKS = 3,
    parameter int FLASH_TICKS  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tick_en,
    input  logic [NUM_PHASES-1:0]         req,
    input  logic                          flash_mode,
    output logic [3*NUM_PHASES-1:0]       led,
    output logic [$clog2(NUM_PHASES)-1:0] active_phase,
    output logic                          phase_start
);

    localparam int PW = $clog2(NUM_PHASES);
    localparam int CW = cnt_width(GREEN_TICKS, YELLOW_TICKS, ALLRED_TICKS, FLASH_TICKS);
    localparam logic [CW-1:0] GREEN_LAST  = CW'(GREEN_TICKS - 1);
    localparam logic [CW-1:0] YELLOW_LAST = CW'(YELLOW_TICKS - 1);
    localparam logic [CW-1:0] ALLRED_LAST = CW'(ALLRED_TICKS - 1);
    localparam logic [CW-1:0] FLASH_LAST  = CW'(FLASH_TICKS - 1);

    phase_state_t  r_state, w_state_next;
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic [PW-1:0] r_active, w_active_next;
    logic          r_phase_start, w_pstart_next;

    logic [PW-1:0] w_rr_next;
    logic          w_any_other;
    logic          w_leave_green;
    logic          w_enter_flash;
    logic [PW-1:0] w_green_phase;

    rr_phase_select #(
        .NUM_PHASES (NUM_PHASES),
        .PW         (PW)
    ) u_rr (
        .i_req       (req),
        .i_active    (r_active),
        .o_next      (w_rr_next),
        .o_any_other (w_any_other)
    );

`ifdef TRAFFIC_FLASH_EN
    logic r_flash_on, w_flash_on_next;
    logic r_from_flash, w_from_flash_next;

    assign w_leave_green = w_any_other | flash_mode;
    assign w_enter_flash = flash_mode;
    // Leaving flash always restarts the cycle at approach 0.
    assign w_green_phase = r_from_flash ? '0 : w_rr_next;
`else
    logic w_unused_flash;

    assign w_unused_flash = flash_mode;
    assign w_leave_green  = w_any_other;
    assign w_enter_flash  = 1'b0;
    assign w_green_phase  = w_rr_next;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_GREEN;
            r_cnt         <= '0;
            r_active      <= '0;
            r_phase_start <= 1'b0;
`ifdef TRAFFIC_FLASH_EN
            r_flash_on    <= 1'b0;
            r_from_flash  <= 1'b0;
`endif
        end else begin
            r_state       <= w_state_next;
            r_cnt         <= w_cnt_next;
            r_active      <= w_active_next;
            r_phase_start <= w_pstart_next;
`ifdef TRAFFIC_FLASH_EN
            r_flash_on    <= w_flash_on_next;
            r_from_flash  <= w_from_flash_next;
`endif
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_active_next = r_active;
        w_pstart_next = 1'b0;
`ifdef TRAFFIC_FLASH_EN
        w_flash_on_next   = r_flash_on;
        w_from_flash_next = r_from_flash;
`endif
        if (tick_en) begin
            unique case (r_state)
                ST_GREEN: begin
                    // At the minimum length the count saturates: rest in green until demand elsewhere.
                    if (r_cnt != GREEN_LAST) begin
                        w_cnt_next = r_cnt + CW'(1);
                    end else if (w_leave_green) begin
                        w_state_next = ST_YELLOW;
                        w_cnt_next   = '0;
                    end
                end
                ST_YELLOW: begin
                    if (r_cnt != YELLOW_LAST) begin
                        w_cnt_next = r_cnt + CW'(1);
                    end else begin
                        w_state_next = ST_ALLRED;
                        w_cnt_next   = '0;
                    end
                end
                ST_ALLRED: begin
                    if (r_cnt != ALLRED_LAST) begin
                        w_cnt_next = r_cnt + CW'(1);
                    end else if (w_enter_flash) begin
                        w_state_next = ST_FLASH;
                        w_cnt_next   = '0;
`ifdef TRAFFIC_FLASH_EN
                        w_flash_on_next = 1'b1;
`endif
                    end else begin
                        w_state_next  = ST_GREEN;
                        w_cnt_next    = '0;
                        w_active_next = w_green_phase;
                        w_pstart_next = 1'b1;
`ifdef TRAFFIC_FLASH_EN
                        w_from_flash_next = 1'b0;
`endif
                    end
                end
`ifdef TRAFFIC_FLASH_EN
                ST_FLASH: begin
                    if (!flash_mode) begin
                        w_state_next      = ST_ALLRED;
                        w_cnt_next        = '0;
                        w_from_flash_next = 1'b1;
                    end else if (r_cnt != FLASH_LAST) begin
                        w_cnt_next = r_cnt + CW'(1);
                    end else begin
                        w_flash_on_next = ~r_flash_on;
                        w_cnt_next      = '0;
                    end
                end
`endif
                default: begin
                    w_state_next = ST_GREEN;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_PHASES; gi++) begin : g_lamp
            logic [2:0] w_lamp;
            logic       w_is_active;

            assign w_is_active = (r_active == PW'(gi));

            always_comb begin
                w_lamp = LAMP_RED;
                case (r_state)
                    ST_GREEN:  if (w_is_active) w_lamp = LAMP_GREEN;
                    ST_YELLOW: if (w_is_active) w_lamp = LAMP_YELLOW;
`ifdef TRAFFIC_FLASH_EN
                    ST_FLASH:  w_lamp = r_flash_on ? LAMP_YELLOW : LAMP_DARK;
`endif
                    default:   w_lamp = LAMP_RED;
                endcase
            end

            assign led[3*gi +: 3] = w_lamp;
        end
    endgenerate

    assign active_phase = r_active;
    assign phase_start  = r_phase_start;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Randomised and directed bench for traffic_phase_ctrl against an interval-based reference model.
// Works in both builds; the model follows TRAFFIC_FLASH_EN.
module tb_traffic_phase_ctrl;

    localparam int N  = 3;
    localparam int G  = 4;
    localparam int Y  = 2;
    localparam int AR = 1;
    localparam int F  = 2;
    localparam int PW = 2;

    localparam int K_GREEN  = 0;
    localparam int K_YELLOW = 1;
    localparam int K_ALLRED = 2;
    localparam int K_FLASH  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          tick_en;
    logic [N-1:0]  req;
    logic          flash_mode;
    logic [3*N-1:0] led;
    logic [PW-1:0] active_phase;
    logic          phase_start;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: which interval we are in and how many ticks of it have elapsed.
    int m_kind;
    int m_elapsed;
    int m_active;
    bit m_pulse;
    bit m_lit;
    bit m_after_flash;

    always #5 clk = ~clk;

    traffic_phase_ctrl #(
        .NUM_PHASES   (N),
        .GREEN_TICKS  (G),
        .YELLOW_TICKS (Y),
        .ALLRED_TICKS (AR),
        .FLASH_TICKS  (F)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tick_en      (tick_en),
        .req          (req),
        .flash_mode   (flash_mode),
        .led          (led),
        .active_phase (active_phase),
        .phase_start  (phase_start)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit flash_req(input logic f);
`ifdef TRAFFIC_FLASH_EN
        return f;
`else
        return 1'b0 & f;
`endif
    endfunction

    function automatic int rr_next(input int cur, input int rv);
        for (int k = 1; k < N; k++) begin
            if (((rv >> ((cur + k) % N)) & 1) != 0) return (cur + k) % N;
        end
        return (cur + 1) % N;
    endfunction

    function automatic int exp_led();
        int v;
        int lamp;
        v = 0;
        for (int i = 0; i < N; i++) begin
            lamp = 4;
            if (m_kind == K_GREEN && i == m_active)  lamp = 1;
            if (m_kind == K_YELLOW && i == m_active) lamp = 2;
            if (m_kind == K_FLASH)                   lamp = m_lit ? 2 : 0;
            v = v | (lamp << (3 * i));
        end
        return v;
    endfunction

    task automatic model_update();
        int rv;
        bit others;
        bit fm;
        rv     = int'(req);
        fm     = flash_req(flash_mode);
        m_pulse = 1'b0;
        if (rst) begin
            m_kind = K_GREEN; m_elapsed = 0; m_active = 0;
            m_lit = 1'b0; m_after_flash = 1'b0;
            return;
        end
        if (!tick_en) return;
        others = (rv & ~(1 << m_active)) != 0;
        case (m_kind)
            K_GREEN: begin
                if (m_elapsed < G - 1) m_elapsed++;
                else if (others || fm) begin m_kind = K_YELLOW; m_elapsed = 0; end
            end
            K_YELLOW: begin
                if (m_elapsed < Y - 1) m_elapsed++;
                else begin m_kind = K_ALLRED; m_elapsed = 0; end
            end
            K_ALLRED: begin
                if (m_elapsed < AR - 1) m_elapsed++;
                else if (fm) begin m_kind = K_FLASH; m_elapsed = 0; m_lit = 1'b1; end
                else begin
                    m_active      = m_after_flash ? 0 : rr_next(m_active, rv);
                    m_after_flash = 1'b0;
                    m_kind        = K_GREEN;
                    m_elapsed     = 0;
                    m_pulse       = 1'b1;
                end
            end
            default: begin
                if (!fm) begin m_kind = K_ALLRED; m_elapsed = 0; m_after_flash = 1'b1; end
                else if (m_elapsed < F - 1) m_elapsed++;
                else begin m_lit = !m_lit; m_elapsed = 0; end
            end
        endcase
    endtask

    task automatic step(input bit t, input logic [N-1:0] r, input bit f, input bit rs);
        rst        = rs;
        tick_en    = t;
        req        = r;
        flash_mode = f;
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_eq("led", 32'(led), 32'(exp_led()));
        check_eq("active_phase", 32'(active_phase), 32'(m_active));
        check_eq("phase_start", 32'(phase_start), 32'(m_pulse));
    endtask

    initial begin
        logic [N-1:0] r;
        bit fm;
        bit t;
        bit rs;

        m_kind = K_GREEN; m_elapsed = 0; m_active = 0;
        m_pulse = 1'b0; m_lit = 1'b0; m_after_flash = 1'b0;

        // Reset values
        step(1'b1, 3'b000, 1'b0, 1'b1);
        step(1'b1, 3'b000, 1'b0, 1'b1);
        check_eq("reset_led", 32'(led), 32'h121);
        check_eq("reset_active", 32'(active_phase), 32'd0);
        check_eq("reset_pstart", 32'(phase_start), 32'd0);
        $display("[TB] reset: led=%b active=%0d", led, active_phase);

        // req[1]: 4 green + 2 yellow + 1 all-red, then approach 1 green
        for (int i = 1; i <= 7; i++) step(1'b1, 3'b010, 1'b0, 1'b0);
        check_eq("p1_led", 32'(led), 32'h10C);
        check_eq("p1_active", 32'(active_phase), 32'd1);
        check_eq("p1_pstart", 32'(phase_start), 32'd1);
        step(1'b1, 3'b010, 1'b0, 1'b0);
        check_eq("pstart_width", 32'(phase_start), 32'd0);
        for (int i = 0; i < 6; i++) step(1'b1, 3'b010, 1'b0, 1'b0);
        $display("[TB] req=010: active=%0d led=%b", active_phase, led);

        // req[2]: approach 1 must stay red throughout
        step(1'b1, 3'b000, 1'b0, 1'b1);
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, 3'b100, 1'b0, 1'b0);
            check_eq("ap1_red", 32'(led[5:3]), 32'h4);
            if (i == 7) check_eq("skip_to_2", 32'(active_phase), 32'd2);
        end
        $display("[TB] req=100: active=%0d led=%b", active_phase, led);

        // Rest in green, late demand, reset during yellow
        step(1'b1, 3'b000, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b1, 3'b000, 1'b0, 1'b0);
        check_eq("rest_green", 32'(led), 32'h121);
        step(1'b1, 3'b010, 1'b0, 1'b0);
        check_eq("rest_to_yellow", 32'(led[2:0]), 32'h2);
        step(1'b1, 3'b010, 1'b0, 1'b1);
        check_eq("rst_in_yellow", 32'(led), 32'h121);
        $display("[TB] rest/late demand/reset: led=%b", led);

        // Sparse ticks: every 4th cycle
        step(1'b1, 3'b000, 1'b0, 1'b1);
        for (int i = 0; i < 80; i++) step((i % 4) == 3, 3'b010, 1'b0, 1'b0);
        $display("[TB] sparse ticks: active=%0d led=%b", active_phase, led);

        // Flash mode request then release
        step(1'b1, 3'b000, 1'b0, 1'b1);
        for (int i = 0; i < 30; i++) step(1'b1, 3'b000, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b1, 3'b000, 1'b0, 1'b0);
        check_eq("after_flash_phase", 32'(active_phase), 32'd0);
        $display("[TB] flash sequence: active=%0d led=%b", active_phase, led);

        // Randomised traffic
        r  = 3'b000;
        fm = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0)  r  = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 63) == 0) fm = !fm;
            t  = ($urandom_range(0, 3) != 0);
            rs = ($urandom_range(0, 299) == 0);
            step(t, r, fm, rs);
        end
        $display("[TB] random traffic: 4000 cycles, active=%0d", active_phase);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
